// File: rtl/key_pkg.sv
// Shared types and defaults for the key capture block.
// Holds FSM state encoding, key-code width and parameter defaults.
package key_pkg;

  localparam int KW        = 4;
  localparam int DEB_DEF   = 4;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } state_t;

endpackage

// File: rtl/key_capture_if.sv
// Consumer-side valid/ready bus for captured key codes.
// dout/dout_valid from the block, dout_ready from the consumer.
interface key_capture_if;
  import key_pkg::*;

  logic [KW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/key_fifo.sv
// First-word-fall-through FIFO for key codes; head reads 0 when empty.
// Ports: clk, rst, i_push/i_din, i_pop, o_dout, o_full, o_empty, o_count.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  logic w_pop;
  logic w_push;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = o_empty ? '0 : r_mem[r_rd];

  // A push into a full FIFO only lands if a pop frees the slot.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/key_capture.sv
// Synchronizes and debounces encoder key codes, queues one code per press.
// Ports: clk, rst, L, GS, dbus (dout/valid/ready), overflow, count.
module key_capture
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_DEF,
  parameter int FIFO_DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KW-1:0]    L,
  input  logic             GS,
  key_capture_if.master    dbus,
  output logic             overflow,
  output logic [3:0]       count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [KW-1:0] r_l1;
  logic [KW-1:0] r_l2;
  logic          r_g1;
  logic          r_g2;
  state_t        r_st;
  logic [3:0]    r_cnt;
  logic [KW-1:0] r_cand;
  logic          r_ovf;

  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_cnt;

  // Push on the stable sample that brings cnt up to DEB_CYCLES.
  assign w_push = (r_st == PRESS_DEB) && r_g2 &&
                  (r_l2 == r_cand) &&
                  (r_cnt == 4'(DEB_CYCLES - 1));

  assign overflow        = r_ovf;
  assign count           = 4'(w_cnt);
  assign dbus.dout_valid = !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_l1   <= '0;
      r_l2   <= '0;
      r_g1   <= 1'b0;
      r_g2   <= 1'b0;
      r_st   <= IDLE;
      r_cnt  <= '0;
      r_cand <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_l1  <= L;
      r_l2  <= r_l1;
      r_g1  <= GS;
      r_g2  <= r_g1;
      r_ovf <= w_push && w_full && !dbus.dout_ready;
      unique case (r_st)
        IDLE: begin
          if (r_g2) begin
            r_cand <= r_l2;
            r_cnt  <= 4'd1;
            r_st   <= PRESS_DEB;
          end
        end
        PRESS_DEB: begin
          if (!r_g2) begin
            r_st <= IDLE;
          end else if (r_l2 != r_cand) begin
            r_cand <= r_l2;
            r_cnt  <= 4'd1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            if (w_push) r_st <= HELD;
          end
        end
        HELD: begin
          if (!r_g2) begin
            r_cnt <= 4'd1;
            r_st  <= REL_DEB;
          end
        end
        REL_DEB: begin
          if (r_g2) begin
            r_st <= HELD;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'(DEB_CYCLES - 1)) r_st <= IDLE;
          end
        end
        default: r_st <= IDLE;
      endcase
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (KW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (r_cand),
    .i_pop   (dbus.dout_ready),
    .o_dout  (dbus.dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

endmodule
